// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage of the RV32I core. Owns the program counter, drives
// the word address into a combinational instruction memory, and registers the
// returned word into a one-entry buffer that feeds decode over valid/ready.
// Fetch stops on the all-zero end marker (halt) or on a misaligned redirect
// target (fault). A redirect always wins and can leave either stopped state.
//
// Ports
//   clk            core clock, rising edge
//   rst            asynchronous active-high reset
//   imem_pc        fetch address (the PC register)
//   imem_data      instruction word at imem_pc, same cycle
//   redirect_valid execute requests a PC change
//   redirect_pc    redirect target
//   out_valid      buffer holds an instruction for decode
//   out_ready      decode accepts this cycle
//   out_instr      buffered instruction
//   out_pc         address of out_instr
//   out_pc_plus4   out_pc + 4 (wraps)
//   halted         end marker fetched, fetching stopped
//   fault          misaligned redirect target, fetching stopped
//
// state    | meaning
// ST_RUN   | fetching one word per free buffer slot
// ST_HALT  | zero word seen; pc frozen until a redirect
// ST_FAULT | misaligned redirect seen; pc frozen until an aligned redirect

module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_pc,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic [31:0] out_pc_plus4,
   output logic        halted,
   output logic        fault
);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_HALT  = 2'd1;
   localparam logic [1:0] ST_FAULT = 2'd2;

   logic [31:0] pc;
   logic [1:0]  state;
   logic        buf_free;
   logic        end_marker;
   logic        target_aligned;

   // Slot is free if empty or being drained by decode this cycle.
   assign buf_free       = !out_valid || out_ready;
   assign end_marker     = (imem_data == 32'h0000_0000);
   assign target_aligned = (redirect_pc[1:0] == 2'b00);

   assign imem_pc      = pc;
   assign out_pc_plus4 = out_pc + 32'd4;
   assign halted       = (state == ST_HALT);
   assign fault        = (state == ST_FAULT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc        <= RESET_PC;
         state     <= ST_RUN;
         out_valid <= 1'b0;
         out_instr <= 32'h0000_0000;
         out_pc    <= 32'h0000_0000;
      end else if (redirect_valid) begin
         // Flush; a handshake completing this cycle is already consumed by decode.
         out_valid <= 1'b0;
         if (target_aligned) begin
            pc    <= redirect_pc;
            state <= ST_RUN;
         end else begin
            state <= ST_FAULT;
         end
      end else begin
         case (state)
            ST_RUN: begin
               if (buf_free) begin
                  if (!end_marker) begin
                     out_valid <= 1'b1;
                     out_instr <= imem_data;
                     out_pc    <= pc;
                     pc        <= pc + 32'd4;
                  end else begin
                     // The zero word never reaches decode; pc parks on it.
                     out_valid <= 1'b0;
                     state     <= ST_HALT;
                  end
               end
            end
            default: begin
               // Stopped: let an already-buffered instruction drain.
               if (out_ready) out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
